// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared widths, sink state encoding and FIFO entry layout for the
//            matrix-engine result sink.
// Contents : IDX_W / DATA_W / CNT_W widths, sink_state_t, fifo_entry_t.
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

  localparam int IDX_W  = 20;
  localparam int DATA_W = 40;
  localparam int CNT_W  = 20;

  // Fixed encodings so the state can be matched by legacy tooling.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    SINK_IDLE  = ST_IDLE,
    SINK_RUN   = ST_RUN,
    SINK_DRAIN = ST_DRAIN,
    SINK_DONE  = ST_DONE
  } sink_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/mm_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mm_sink_fifo
// Purpose  : DEPTH-entry synchronous FIFO of result entries with a registered
//            head output (head holds the oldest entry while not empty).
// Ports    : clk, reset (sync, active-high)
//            push, push_data  - write side (ignored when full unless popping)
//            pop              - remove head (ignored when empty)
//            full, empty      - occupancy flags
//            head             - registered oldest entry, zero after reset
// Revision : 1.0 - initial release
// ============================================================================
module mm_sink_fifo
  import mm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output fifo_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [LW-1:0] level;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Head tracks mem[rd_ptr]: the pushed entry becomes head when nothing
      // older will remain; otherwise a pop advances to the next stored entry.
      if (do_push && (empty || (do_pop && level == LW'(1)))) begin
        head <= push_data;
      end else if (do_pop && level > LW'(1)) begin
        head <= mem[rd_next];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_result_sink.sv
`default_nettype none
// ============================================================================
// Module   : mm_result_sink
// Purpose  : Captures matrix-engine result writes (write=1, read=0) into a
//            FIFO, presents them on a valid/ready stream, counts accepted
//            results, flags dropped ones and reports completion once the
//            engine has finished and the FIFO has drained.
// Ports    : clk, reset (sync, active-high)
//            read, write, i, j, write_data, finish - engine side
//            out_valid, out_ready, out_row, out_col, out_data - stream side
//            count    - accepted results since reset (wraps mod 2^20)
//            overflow - sticky, a result was dropped
//            done     - finished and drained
//            checksum - wrapping sum of accepted data (MM_SINK_CHECKSUM_EN)
// Options  : define MM_SINK_CHECKSUM_EN to add the checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module mm_result_sink
  import mm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [IDX_W-1:0]  i,
  input  logic [IDX_W-1:0]  j,
  input  logic [DATA_W-1:0] write_data,
  input  logic              finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              done
`ifdef MM_SINK_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  sink_state_t state;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        capture;
  logic        open_phase;
  logic        pop;
  logic        accept;

  // write together with read is the engine fetching dimensions, not a result.
  assign capture    = write && !read;
  assign open_phase = (state == SINK_IDLE) || (state == SINK_RUN);
  assign pop        = !fifo_empty && out_ready;
  assign accept     = capture && open_phase && (!fifo_full || pop);
  assign push_entry = '{row: i, col: j, data: write_data};

  mm_sink_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign out_valid = !fifo_empty;
  assign out_row   = head.row;
  assign out_col   = head.col;
  assign out_data  = head.data;
  assign done      = (state == SINK_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SINK_IDLE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        count <= count + CNT_W'(1);
      end
      if (capture && !accept) begin
        overflow <= 1'b1;
      end
      case (state)
        SINK_IDLE: begin
          // finish wins over the IDLE->RUN move; a same-cycle capture is
          // still accepted above before draining starts.
          if (finish) begin
            state <= SINK_DRAIN;
          end else if (accept) begin
            state <= SINK_RUN;
          end
        end
        SINK_RUN: begin
          if (finish) begin
            state <= SINK_DRAIN;
          end
        end
        SINK_DRAIN: begin
          if (fifo_empty) begin
            state <= SINK_DONE;
          end
        end
        SINK_DONE: begin
          state <= SINK_DONE;
        end
        default: begin
          state <= SINK_IDLE;
        end
      endcase
    end
  end

`ifdef MM_SINK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + write_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/mm_result_sink.md
MM_RESULT_SINK -- requirements
Module: mm_result_sink

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port read  input  1  matrix-engine read strobe.
REQ-005 Port write  input  1  matrix-engine write strobe.
REQ-006 Port i  input  20  engine row index of result.
REQ-007 Port j  input  20  engine column index of result.
REQ-008 Port write_data  input  40  signed two's-complement result element.
REQ-009 Port finish  input  1  engine completion flag (single-cycle pulse).
REQ-010 Port out_valid  output  1  head FIFO entry present on out_*.
REQ-011 Port out_ready  input  1  consumer accepts head entry when high with out_valid.
REQ-012 Port out_row / out_col  output  20 each  indices of head entry.
REQ-013 Port out_data  output  40  value of head entry.
REQ-014 Port count  output  20  number of results accepted since reset.
REQ-015 Port overflow  output  1  sticky: a result was dropped.
REQ-016 Port done  output  1  all results accepted and drained.

Function
REQ-017 Capture condition SHALL be write==1 and read==0 in the same cycle; write with read==1 (dimension fetch phase) SHALL be ignored.
REQ-018 A capture SHALL push {i, j, write_data} into the FIFO; the entry SHALL appear on out_* no earlier than the next cycle.
REQ-019 Pop SHALL occur when out_valid && out_ready; out_row/out_col/out_data SHALL hold stable while out_valid && !out_ready.
REQ-020 Capture when full with simultaneous pop SHALL be accepted; capture when full without pop SHALL be dropped and set overflow.
REQ-021 Capture when empty SHALL not bypass: out_valid rises one cycle after capture.
REQ-022 count SHALL increment by 1 per accepted capture, wrapping modulo 2^20; dropped captures SHALL not count.
REQ-023 State machine IDLE, RUN, DRAIN, DONE: IDLE->RUN on first accepted capture; RUN->DRAIN when finish==1; IDLE->DRAIN on finish with no captures; DRAIN->DONE when FIFO empty; DONE holds until reset.
REQ-024 finish and a capture in the same cycle SHALL accept the capture, then enter DRAIN.
REQ-025 Captures in DRAIN or DONE SHALL be dropped and set overflow.
REQ-026 done SHALL be 1 exactly in state DONE.

Reset
REQ-027 On reset: FIFO empty, out_valid=0, out_row=0, out_col=0, out_data=0, count=0, overflow=0, done=0, state IDLE.
REQ-028 Reset mid-operation SHALL discard all FIFO contents in that cycle; inputs sampled in the reset cycle SHALL be ignored.

Configuration
REQ-029 Macro MM_SINK_CHECKSUM_EN, when defined, SHALL add output checksum (40 bits): wrapping sum of all accepted write_data values, reset to 0, updated the cycle after each accepted capture.
REQ-030 Without MM_SINK_CHECKSUM_EN the checksum port and adder SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package mm_pkg SHALL hold IDX_W=20, DATA_W=40, the sink state enum, and the FIFO entry struct {row, col, data}.
REQ-032 The FIFO SHALL be sub-module mm_sink_fifo (parameter DEPTH, push/pop/full/empty, registered head output).

Verification
REQ-033 Reset, write=1 read=1 for 3 cycles -> no capture, out_valid=0, count=0.
REQ-034 Captures (0,0,5),(0,1,-3) with out_ready=1 -> out_* shows (0,0,5) then (0,1,0xFFFFFFFFFD), count=2.
REQ-035 DEPTH=4, out_ready=0, 5 captures -> 4 held, overflow=1, count=4; then out_ready=1 -> 4 pops in order.
REQ-036 Full FIFO, capture with simultaneous pop -> accepted, overflow stays 0.
REQ-037 Capture and finish same cycle, out_ready=1 -> entry popped, done=1 the cycle after FIFO empties; later capture -> overflow=1.
REQ-038 MM_SINK_CHECKSUM_EN defined, captures 7 and -2 -> checksum=5; reset mid-run -> all outputs return to REQ-027 values.
